// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional-unit result ports,
// with a one-cycle registered broadcast of the winner's tag, value and branch outcome.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned ROB_TAG_W = 5,
  parameter int unsigned XLEN_P    = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [NUM_FU-1:0]             fu_done,
  input  logic [NUM_FU*ROB_TAG_W-1:0]   fu_rob_tag,
  input  logic [NUM_FU*XLEN_P-1:0]      fu_v,
  input  logic [NUM_FU-1:0]             fu_take_branch,
  input  logic [NUM_FU*XLEN_P-1:0]      fu_branch_loc,
  output logic [NUM_FU-1:0]             ack,
  output logic                          cdb_valid,
  output logic [ROB_TAG_W-1:0]          cdb_rob_tag,
  output logic [XLEN_P-1:0]             cdb_v,
  output logic                          cdb_take_branch,
  output logic [XLEN_P-1:0]             cdb_branch_loc
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 grant_en;

  logic [ROB_TAG_W-1:0] tag_a [NUM_FU];
  logic [XLEN_P-1:0]    v_a   [NUM_FU];
  logic [XLEN_P-1:0]    loc_a [NUM_FU];

  // Unpack the flat per-FU buses into arrays indexed by FU number
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      tag_a[i] = fu_rob_tag[i*ROB_TAG_W +: ROB_TAG_W];
      v_a[i]   = fu_v[i*XLEN_P +: XLEN_P];
      loc_a[i] = fu_branch_loc[i*XLEN_P +: XLEN_P];
    end
  end

  // First ready FU at or after rr_ptr, wrapping modulo NUM_FU
  always_comb begin : rr_search
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_FU;
      if (!grant_valid && fu_done[PTR_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  // Reset and squash both suppress the grant in the same cycle
  always_comb begin
    grant_en = grant_valid && !reset && !squash;
    ack      = '0;
    if (grant_en) begin
      ack = NUM_FU'(1) << grant_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr          <= '0;
      cdb_valid       <= 1'b0;
      cdb_rob_tag     <= '0;
      cdb_v           <= '0;
      cdb_take_branch <= 1'b0;
      cdb_branch_loc  <= '0;
    end else if (grant_en) begin
      rr_ptr          <= (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);
      cdb_valid       <= 1'b1;
      cdb_rob_tag     <= tag_a[grant_idx];
      cdb_v           <= v_a[grant_idx];
      cdb_take_branch <= fu_take_branch[grant_idx];
      cdb_branch_loc  <= loc_a[grant_idx];
    end else begin
      cdb_valid       <= 1'b0;
      cdb_rob_tag     <= '0;
      cdb_v           <= '0;
      cdb_take_branch <= 1'b0;
      cdb_branch_loc  <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: table of per-cycle vectors plus hand
// sequences; broadcast expectations are queued at drive time and popped a cycle later.
module tb_cdb_arbiter;

  localparam int unsigned NF = 4;
  localparam int unsigned TW = 5;
  localparam int unsigned XW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              squash;
  logic [NF-1:0]     fu_done;
  logic [NF*TW-1:0]  fu_rob_tag;
  logic [NF*XW-1:0]  fu_v;
  logic [NF-1:0]     fu_take_branch;
  logic [NF*XW-1:0]  fu_branch_loc;
  logic [NF-1:0]     ack;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_rob_tag;
  logic [XW-1:0]     cdb_v;
  logic              cdb_take_branch;
  logic [XW-1:0]     cdb_branch_loc;

  cdb_arbiter #(.NUM_FU(NF), .ROB_TAG_W(TW), .XLEN_P(XW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_done(fu_done), .fu_rob_tag(fu_rob_tag), .fu_v(fu_v),
    .fu_take_branch(fu_take_branch), .fu_branch_loc(fu_branch_loc),
    .ack(ack), .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_v(cdb_v),
    .cdb_take_branch(cdb_take_branch), .cdb_branch_loc(cdb_branch_loc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        sq;
    logic [3:0]  done;
    logic [3:0]  exp_ack;
    int unsigned exp_ptr;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [TW-1:0] tag;
    logic [XW-1:0] v;
    logic        tb;
    logic [XW-1:0] loc;
    int unsigned ptr;
  } exp_t;

  vec_t vecs [25];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic sq, input logic [3:0] done,
                              input logic [3:0] a, input int unsigned p);
    vec_t r;
    r.rst = rst; r.sq = sq; r.done = done; r.exp_ack = a; r.exp_ptr = p;
    return r;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, " cdb_valid"},       64'(cdb_valid),       64'(e.valid));
    chk({tag, " cdb_rob_tag"},     64'(cdb_rob_tag),     64'(e.tag));
    chk({tag, " cdb_v"},           64'(cdb_v),           64'(e.v));
    chk({tag, " cdb_take_branch"}, 64'(cdb_take_branch), 64'(e.tb));
    chk({tag, " cdb_branch_loc"},  64'(cdb_branch_loc),  64'(e.loc));
    chk({tag, " rr_ptr"},          64'(dut.rr_ptr),      64'(e.ptr));
  endtask

  // One cycle: check last broadcast, drive new inputs, check ack, queue expectation
  task automatic step(input string tag, input logic rst, input logic sq, input logic [3:0] done,
                      input logic [3:0] exp_ack, input int unsigned exp_ptr, input bit rnd);
    exp_t e;
    @(negedge clock);
    pop_check(tag);
    reset = rst; squash = sq; fu_done = done;
    if (rnd) begin
      fu_rob_tag     = 20'($urandom);
      fu_v           = {$urandom, $urandom, $urandom, $urandom};
      fu_take_branch = 4'($urandom);
      fu_branch_loc  = {$urandom, $urandom, $urandom, $urandom};
    end
    #1;
    chk({tag, " ack"}, 64'(ack), 64'(exp_ack));
    e = '{valid: 1'b0, tag: '0, v: '0, tb: 1'b0, loc: '0, ptr: exp_ptr};
    for (int g = 0; g < 4; g++) begin
      if (exp_ack == (4'b0001 << g) && !rst && !sq) begin
        e.valid = 1'b1;
        e.tag   = fu_rob_tag[g*TW +: TW];
        e.v     = fu_v[g*XW +: XW];
        e.tb    = fu_take_branch[g];
        e.loc   = fu_branch_loc[g*XW +: XW];
      end
    end
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; fu_done = '0;
    fu_rob_tag = '0; fu_v = '0; fu_take_branch = '0; fu_branch_loc = '0;

    vecs[0]  = mk(1, 0, 4'b1111, 4'b0000, 0);
    vecs[1]  = mk(1, 0, 4'b0000, 4'b0000, 0);
    vecs[2]  = mk(0, 0, 4'b0100, 4'b0100, 3);
    vecs[3]  = mk(0, 0, 4'b1001, 4'b1000, 0);
    vecs[4]  = mk(0, 0, 4'b0001, 4'b0001, 1);
    vecs[5]  = mk(0, 0, 4'b1111, 4'b0010, 2);
    vecs[6]  = mk(0, 0, 4'b1111, 4'b0100, 3);
    vecs[7]  = mk(0, 0, 4'b1111, 4'b1000, 0);
    vecs[8]  = mk(0, 0, 4'b1111, 4'b0001, 1);
    vecs[9]  = mk(0, 0, 4'b1111, 4'b0010, 2);
    vecs[10] = mk(0, 0, 4'b1111, 4'b0100, 3);
    vecs[11] = mk(0, 0, 4'b1111, 4'b1000, 0);
    vecs[12] = mk(0, 0, 4'b1111, 4'b0001, 1);
    vecs[13] = mk(0, 0, 4'b0000, 4'b0000, 1);
    vecs[14] = mk(0, 0, 4'b0000, 4'b0000, 1);
    vecs[15] = mk(0, 0, 4'b0000, 4'b0000, 1);
    vecs[16] = mk(0, 1, 4'b0010, 4'b0000, 1);
    vecs[17] = mk(0, 0, 4'b0010, 4'b0010, 2);
    vecs[18] = mk(0, 0, 4'b0010, 4'b0010, 2);
    vecs[19] = mk(0, 0, 4'b0011, 4'b0001, 1);
    vecs[20] = mk(0, 0, 4'b0110, 4'b0010, 2);
    vecs[21] = mk(1, 0, 4'b0100, 4'b0000, 0);
    vecs[22] = mk(0, 0, 4'b1111, 4'b0001, 1);
    vecs[23] = mk(1, 1, 4'b1111, 4'b0000, 0);
    vecs[24] = mk(0, 0, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < 25; i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].sq, vecs[i].done,
           vecs[i].exp_ack, vecs[i].exp_ptr, 1'b1);

    // Single FU2 result after reset with fixed data
    step("h1_rst", 1, 0, 4'b0000, 4'b0000, 0, 1'b1);
    fu_rob_tag = '0; fu_v = '0; fu_take_branch = '0; fu_branch_loc = '0;
    fu_rob_tag[2*TW +: TW] = 5'd7;
    fu_v[2*XW +: XW]       = 32'h0000_00AA;
    step("h1_grant", 0, 0, 4'b0100, 4'b0100, 3, 1'b0);
    @(posedge clock); #1;
    chk("h1 fixed tag", 64'(cdb_rob_tag), 64'd7);
    chk("h1 fixed v",   64'(cdb_v),       64'h0000_00AA);

    // All FUs ready from reset: strict rotation, tags follow FU order twice
    step("h2_rst", 1, 0, 4'b0000, 4'b0000, 0, 1'b1);
    for (int i = 0; i < NF; i++) fu_rob_tag[i*TW +: TW] = TW'(10 + i);
    for (int c = 0; c < 8; c++) begin
      step($sformatf("h2_rr%0d", c), 0, 0, 4'b1111, 4'b0001 << (c % 4), (c + 1) % 4, 1'b0);
      @(posedge clock); #1;
      chk($sformatf("h2 tag%0d", c), 64'(cdb_rob_tag), 64'(10 + (c % 4)));
    end

    // Taken branch on FU1 squashed in the same cycle
    fu_take_branch = 4'b0010;
    fu_branch_loc[1*XW +: XW] = 32'h0000_1040;
    step("h3_sq", 0, 1, 4'b0010, 4'b0000, 0, 1'b0);
    step("h3_idle", 0, 0, 4'b0000, 4'b0000, 0, 1'b0);
    step("h3_end", 0, 0, 4'b0000, 4'b0000, 0, 1'b1);
    @(negedge clock);
    pop_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
